// File: rtl/fll_cfg_arbiter.sv
// fll_cfg_arbiter: round-robin sharing of the FLL four-phase config port with per-edge ack timeout
module fll_cfg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
  input  logic [NUM_REQ-1:0]         web_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       err_o,
  output logic                       fll_req_o,
  input  logic                       fll_ack_i,
  output logic [ADDR_W-1:0]          fll_addr_o,
  output logic [DATA_W-1:0]          fll_wdata_o,
  output logic                       fll_web_o,
  input  logic [DATA_W-1:0]          fll_rdata_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last, gnt, sel;
  logic found;
  logic [NUM_REQ-1:0] mask;
  assign mask = req_i & ~ack_o;
  always_comb begin
    found = 1'b0;
    sel = last;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!found && mask[(int'(last) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel = IW'((int'(last) + i) % NUM_REQ);
      end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      fll_req_o <= 1'b0;
      fll_addr_o <= '0;
      fll_wdata_o <= '0;
      fll_web_o <= 1'b1;
      ack_o <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
      cnt <= '0;
      last <= IW'(NUM_REQ - 1);
      gnt <= '0;
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      case (state)
        IDLE: if (found) begin
          fll_addr_o <= addr_i[sel*ADDR_W +: ADDR_W];
          fll_wdata_o <= wdata_i[sel*DATA_W +: DATA_W];
          fll_web_o <= web_i[sel];
          fll_req_o <= 1'b1;
          gnt <= sel;
          last <= sel;
          cnt <= '0;
          state <= REQ;
        end
        REQ: if (fll_ack_i) begin
          rdata_o <= fll_rdata_i;
          ack_o <= NUM_REQ'(1) << gnt;
          fll_req_o <= 1'b0;
          cnt <= '0;
          state <= RELEASE;
        end else if (cnt == TMAX) begin
          rdata_o <= '0;
          ack_o <= NUM_REQ'(1) << gnt;
          err_o <= 1'b1;
          fll_req_o <= 1'b0;
          cnt <= '0;
          state <= RELEASE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RELEASE: if (!fll_ack_i || cnt == TMAX) state <= IDLE;
                 else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fll_cfg_arbiter.md
Name: fll_cfg_arbiter

Overview:
- Shares the single FLL configuration port (req/ack/addr/wdata/rdata/web) between NUM_REQ requesters, e.g. the SoC APB bridge and the JTAG/debug path.
- Sequences one four-phase transaction at a time toward the FLL: req, then ack, then req drop, then ack drop.
- Arbitrates round-robin between requesters.
- Applies a timeout so that an unclocked or powered-down FLL cannot hang a requester.
- Sits in the clock/reset generation domain, directly in front of the FLL macro, and is clocked by the reference clock.

Parameters:
- NUM_REQ, 2, number of requesters (≥1).
- ADDR_W, 2, FLL config address width.
- DATA_W, 32, FLL config data width.
- TIMEOUT, 255, maximum cycles to wait for each ack edge (≥1).

Ports:
- clk_i  in  1  reference clock; the only clock of the block.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester request, level; held until its ack_o pulse.
- addr_i  in  NUM_REQ*ADDR_W  per-requester address, slice k.
- wdata_i  in  NUM_REQ*DATA_W  per-requester write data.
- web_i  in  NUM_REQ  per-requester write enable, active low (0=write, 1=read).
- ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata_o  out  DATA_W  read data; valid only while any ack_o bit is 1, shared by all requesters.
- err_o  out  1  timeout flag; valid with ack_o.
- fll_req_o  out  1  FLL config request.
- fll_ack_i  in  1  FLL config acknowledge.
- fll_addr_o  out  ADDR_W  FLL address.
- fll_wdata_o  out  DATA_W  FLL write data.
- fll_web_o  out  1  FLL write enable, active low.
- fll_rdata_i  in  DATA_W  FLL read data, valid while fll_ack_i=1.

Behaviour:
- **Reset values** (at any clk_i edge with rst_i=1, including mid-transaction):
  - state=IDLE; fll_req_o=0, fll_addr_o=0, fll_wdata_o=0, fll_web_o=1.
  - ack_o=0, rdata_o=0, err_o=0, timeout counter=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
  - An aborted transaction is not acknowledged; its requester re-arbitrates after reset.
- **Outputs**: all registered; no combinational path from any input to any output.
- **IDLE**:
  - If any req_i bit is 1 and no ack_o is currently pulsing to that requester, grant g = first set index scanning last+1, last+2, … with wrap modulo NUM_REQ.
  - On grant, register addr/wdata/web of g onto fll_*, set fll_req_o=1, store g, set last=g, clear the counter, go to REQ.
  - Grant-to-fll_req_o latency is 1 cycle.
- **REQ**:
  - fll_req_o=1; fll_* held stable.
  - If fll_ack_i=1: capture fll_rdata_i into rdata_o; pulse ack_o[g]=1 for one cycle with err_o=0; set fll_req_o=0; go to RELEASE.
  - Else, if the counter reaches TIMEOUT: set fll_req_o=0, rdata_o=0, pulse ack_o[g] with err_o=1, go to RELEASE.
  - Else increment the counter.
- **RELEASE**:
  - Wait for fll_ack_i=0, then go to IDLE.
  - The counter restarts on entry; on reaching TIMEOUT, go to IDLE anyway (err not re-signalled).
  - fll_req_o stays 0.
- **Requester contract**:
  - Requester drops req_i in the cycle after seeing ack_o.
  - Because ack_o was pulsed when leaving REQ, the earliest next grant happens in IDLE after RELEASE. A stale req_i cycle therefore never causes a double grant.
  - The arbiter also masks the requester whose ack_o is high that cycle.
- **Simultaneous requests**: served strictly round-robin; a requester that keeps requesting waits at most NUM_REQ-1 other transactions.
- **fll_ack_i outside REQ/RELEASE**: ignored.
- **Single requester** (NUM_REQ=1): always granted; pointer logic degenerates.
- **Counter**: width $clog2(TIMEOUT+1); saturates, never wraps.
- **Single transaction, FLL ack after d cycles** (d < TIMEOUT): ack_o occurs d+2 cycles after req_i is sampled.

Test Plan:
- Reset then req_i=01, web=0, addr=2, wdata=0xA5A5_0001, fll_ack_i after 3 cycles → fll_req_o rises 1 cycle after req sampled with fll_addr_o=2 and fll_wdata_o=0xA5A5_0001; ack_o=01 for exactly one cycle; err_o=0.
- Read: req_i=10, web=1, FLL returns 0x1234_5678 with ack → rdata_o=0x1234_5678 coincident with ack_o=10.
- req_i=11 held continuously, 4 transactions → grant order 0,1,0,1; no back-to-back fll_req_o without an intervening fll_ack_i low.
- TIMEOUT=8, fll_ack_i tied 0 → ack_o pulse with err_o=1 and rdata_o=0 after the timeout; next request is served normally.
- rst_i asserted while in REQ → fll_req_o=0 at the next edge; no ack_o; after release, requester 0 is granted first.
- fll_ack_i stuck 1 after a transaction → RELEASE times out; the next grant proceeds; fll_ack_i=1 while in IDLE produces no ack_o.
